uart_rx_deserializer: RTL and testbench

Oversampling UART receiver that turns the raw `uart_rx` pin into a validated byte stream for the command controller in the TPU host path. It sits directly upstream of the UART controller's command parser, which drives weight FIFO pushes, activation loads and MLP start. Its main jobs:
- Synchronise the pin and decode 8N1 frames with 3-sample majority voting.
- Hold one received byte behind a valid/ready handshake.
- Flag framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_deserializer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_rx_deserializer                                                   |
// | 16x oversampling 8N1 receiver with majority voting and a valid/ready   |
// | holding register; framing-error and overrun reported as pulses.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module uart_rx_deserializer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam logic [3:0] PH_SAMPLE0 = 4'd7;
  localparam logic [3:0] PH_SAMPLE1 = 4'd8;
  localparam logic [3:0] PH_DECIDE  = 4'd9;
  localparam logic [3:0] BIT_LAST_DATA = 4'd8;
  localparam logic [3:0] BIT_STOP      = 4'd9;

  generate
    if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx_deserializer: OVERSAMPLE must be 16");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_rx_deserializer: CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic             sync1_q,     sync1_d;
  logic             sync2_q,     sync2_d;
  logic             prev_q,      prev_d;
  logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
  logic [7:0]       scnt_q,      scnt_d;
  logic [1:0]       samp_q,      samp_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic             done_q,      done_d;
  logic             stop_ok_q,   stop_ok_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  logic       w_fall;
  logic       w_tick;
  logic [7:0] w_tick_num;
  logic [3:0] w_phase;
  logic [3:0] w_bit_idx;
  logic       w_majority;
  logic       w_decide;
  logic       w_deliver;

  // w_tick_num is the index of the tick firing this cycle (ticks count from 1).
  assign w_fall     = prev_q & ~sync2_q;
  assign w_tick     = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
  assign w_tick_num = scnt_q + 8'd1;
  assign w_phase    = w_tick_num[3:0];
  assign w_bit_idx  = w_tick_num[7:4];
  assign w_majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign w_decide   = w_tick && (w_phase == PH_DECIDE);
  assign w_deliver  = done_q & stop_ok_q;

  always_comb begin
    state_d     = state_q;
    sync1_d     = uart_rx;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    div_cnt_d   = div_cnt_q;
    scnt_d      = scnt_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    stop_ok_d   = stop_ok_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (state_q == S_IDLE) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (w_tick) begin
      scnt_d = w_tick_num;
      if (w_phase == PH_SAMPLE0) begin
        samp_d[0] = sync2_q;
      end
      if (w_phase == PH_SAMPLE1) begin
        samp_d[1] = sync2_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (w_fall) begin
          state_d = S_START;
          scnt_d  = 8'd0;
        end
      end
      S_START: begin
        if (w_decide) begin
          state_d = w_majority ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_decide) begin
          shreg_d = {w_majority, shreg_q[7:1]};
          if (w_bit_idx == BIT_LAST_DATA) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // The verdict is registered first, so the result lands one cycle after tick 153.
        if (done_q) begin
          state_d = S_IDLE;
        end else if (w_decide && (w_bit_idx == BIT_STOP)) begin
          done_d    = 1'b1;
          stop_ok_d = w_majority;
        end
      end
      default: state_d = S_IDLE;
    endcase

    frame_err_d = done_q & ~stop_ok_q;

    if (w_deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      div_cnt_q   <= '0;
      scnt_q      <= 8'd0;
      samp_q      <= 2'b00;
      shreg_q     <= 8'd0;
      done_q      <= 1'b0;
      stop_ok_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_cnt_q   <= div_cnt_d;
      scnt_q      <= scnt_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
      stop_ok_q   <= stop_ok_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_uart_rx_deserializer                                                |
// | Directed + randomized frames against a frame-level expectation model.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_uart_rx_deserializer;

  localparam int CLOCK_FREQ = 4_000_000;
  localparam int BAUD_RATE  = 62_500;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CPB        = DIV * OVERSAMPLE;
  localparam int FRAME_LAT  = 153 * DIV + 1;
  localparam int FALSE_LAT  = 9 * DIV;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       uart_rx  = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  int tests  = 0;
  int failed = 0;

  // Observed activity, sampled 1 ns after each rising edge.
  int         cyc          = 0;
  int         t_start      = 0;
  int         n_start      = 0;
  int         n_valid_rise = 0;
  int         n_valid_hi   = 0;
  int         n_ferr       = 0;
  int         n_ovr        = 0;
  int         lat_valid    = -1;
  int         lat_ferr     = -1;
  int         lat_ovr      = -1;
  int         lat_false    = -1;
  logic [3:0] seen         = 4'b0000;
  logic [1:0] prev_state   = 2'd0;
  logic       prev_valid   = 1'b0;
  logic [7:0] prev_data    = 8'd0;
  logic [7:0] got_q[$];

  logic [7:0] exp_q[$];
  int         rd_idx = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!rst) begin
      prev_state = 2'd0;
      prev_valid = 1'b0;
      prev_data  = 8'd0;
    end else begin
      seen[dbg_state] = 1'b1;
      if (prev_state == 2'd0 && dbg_state == 2'd1) begin
        n_start = n_start + 1;
        t_start = cyc;
      end
      if (prev_state == 2'd1 && dbg_state == 2'd0) lat_false = cyc - t_start;
      if (prev_valid && rx_ready) got_q.push_back(prev_data);
      if (rx_valid) n_valid_hi = n_valid_hi + 1;
      if (rx_valid && !prev_valid) begin
        n_valid_rise = n_valid_rise + 1;
        lat_valid    = cyc - t_start;
      end
      if (frame_err) begin
        n_ferr   = n_ferr + 1;
        lat_ferr = cyc - t_start;
      end
      if (overrun) begin
        n_ovr   = n_ovr + 1;
        lat_ovr = cyc - t_start;
      end
      prev_state = dbg_state;
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, each bit held for CPB cycles; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = rd_idx; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    end
    rd_idx = exp_q.size();
  endtask

  initial begin
    int         s_start, s_vrise, s_vhi, s_ferr, s_ovr, glen;
    logic [7:0] fixed[3];
    logic [7:0] b;
    logic [9:0] f;

    fixed[0] = 8'h00;
    fixed[1] = 8'hFF;
    fixed[2] = 8'h3C;

    repeat (4) @(negedge clk);
    check("reset rx_data",   rx_data,   32'h00);
    check("reset rx_valid",  rx_valid,  32'h0);
    check("reset frame_err", frame_err, 32'h0);
    check("reset overrun",   overrun,   32'h0);
    check("reset dbg_state", dbg_state, 32'h0);
    rst = 1'b1;
    idle(2 * CPB);

    // Single byte
    s_vhi = n_valid_hi; s_ferr = n_ferr; s_ovr = n_ovr;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    idle(CPB);
    check_stream("single");
    check("single latency",         lat_valid,           FRAME_LAT);
    check("single rx_valid cycles", n_valid_hi - s_vhi,  1);
    check("single frame_err",       n_ferr - s_ferr,     0);
    check("single overrun",         n_ovr - s_ovr,       0);

    // Back-to-back frames, then random bytes with random gaps
    s_ferr = n_ferr; s_ovr = n_ovr;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) b = fixed[i];
      else       b = 8'($urandom);
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      if (i >= 3) idle($urandom_range(0, 40));
    end
    idle(CPB);
    check_stream("b2b");
    check("b2b states seen", seen,            32'hF);
    check("b2b frame_err",   n_ferr - s_ferr, 0);
    check("b2b overrun",     n_ovr - s_ovr,   0);

    // False starts of random short length
    s_start = n_start; s_vrise = n_valid_rise; s_ferr = n_ferr;
    for (int g = 0; g < 3; g++) begin
      glen = $urandom_range(4, 24);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (glen) @(negedge clk);
      uart_rx = 1'b1;
      idle(CPB);
      check($sformatf("false start %0d return tick", g), lat_false, FALSE_LAT);
    end
    check("false start count",    n_start - s_start,      3);
    check("false start rx_valid", n_valid_rise - s_vrise, 0);
    check("false start frame_err", n_ferr - s_ferr,       0);
    check("false start state",    dbg_state,              32'h0);

    // Framing error; line then stays low
    s_start = n_start; s_vrise = n_valid_rise; s_ferr = n_ferr;
    send_frame(8'h5A, 1'b0);
    idle(5 * CPB);
    check("ferr pulse cycles", n_ferr - s_ferr,        1);
    check("ferr latency",      lat_ferr,               FRAME_LAT);
    check("ferr rx_valid",     n_valid_rise - s_vrise, 0);
    check("ferr low line starts", n_start - s_start,   1);
    check("ferr state idle",   dbg_state,              32'h0);
    uart_rx = 1'b1;
    idle(CPB);
    check_stream("ferr");

    // Overrun, then simultaneous drain and load
    s_ovr = n_ovr; s_ferr = n_ferr;
    @(negedge clk);
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(CPB);
    check("ovr held valid",    rx_valid,        32'h1);
    check("ovr held data",     rx_data,         32'h11);
    check("ovr pulse cycles",  n_ovr - s_ovr,   1);
    check("ovr latency",       lat_ovr,         FRAME_LAT);
    check("ovr frame_err",     n_ferr - s_ferr, 0);
    check_stream("ovr held");
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      begin
        @(negedge clk);
        repeat (FRAME_LAT + 2) @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #2;
        check("ovr reload valid", rx_valid, 32'h1);
        check("ovr reload data",  rx_data,  32'h33);
      end
    join
    idle(CPB);
    check_stream("ovr drain");
    check("ovr no extra pulse", n_ovr - s_ovr, 1);

    // Reset in the middle of data bit 4
    s_ferr = n_ferr;
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = f[5];
    repeat (CPB / 2) @(negedge clk);
    check("midframe state", dbg_state, 32'h2);
    rst = 1'b0;
    #1;
    check("async rst rx_data",   rx_data,   32'h00);
    check("async rst rx_valid",  rx_valid,  32'h0);
    check("async rst frame_err", frame_err, 32'h0);
    check("async rst overrun",   overrun,   32'h0);
    check("async rst dbg_state", dbg_state, 32'h0);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(CPB);
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    idle(CPB);
    check_stream("after reset");
    check("after reset latency",   lat_valid,       FRAME_LAT);
    check("after reset frame_err", n_ferr - s_ferr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
